// File: rtl/layer3_pool_store.sv
// Row-major feature-map store between layer-3 maxpool and layer 4: fills from the pool
// stage, hands the map to layer 4, then serves zero-padded single-cycle reads.
module layer3_pool_store #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int OUT_H  = 13,
    parameter int OUT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] output_row,
    input  logic [ADDR_W-1:0] output_col,
    input  logic [DATA_W-1:0] output_data,
    input  logic              layer3_calculation_done,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    input  logic              layer4_release,
    output logic              pixel_store_done,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic [ADDR_W-1:0] store_count,
    output logic              write_error
);

    localparam int DEPTH = OUT_H * OUT_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] W_IDX = IDX_W'(OUT_W);
    localparam logic [ADDR_W-1:0] H_LIM = ADDR_W'(OUT_H);
    localparam logic [ADDR_W-1:0] W_LIM = ADDR_W'(OUT_W);

    typedef enum logic [1:0] {FILL, DONE, READ} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read addresses may legitimately be -1 for padding, so they are viewed as signed.
    logic signed [ADDR_W-1:0] rd_row_s;
    logic signed [ADDR_W-1:0] rd_col_s;

    logic wr_in_map;
    logic wr_ok;
    logic rd_req;
    logic rd_in_map;

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
        return IDX_W'(row) * W_IDX + IDX_W'(col);
    endfunction

    function automatic logic in_range(input logic signed [ADDR_W-1:0] row,
                                      input logic signed [ADDR_W-1:0] col);
        return (row >= 0) && (col >= 0) &&
               (ADDR_W'(row) < H_LIM) && (ADDR_W'(col) < W_LIM);
    endfunction

    always_comb begin
        rd_row_s  = signed'(read_row_addr);
        rd_col_s  = signed'(read_col_addr);
        wr_in_map = (output_row < H_LIM) && (output_col < W_LIM);
        wr_ok     = save_enable && (state == FILL) && wr_in_map;
        rd_req    = read_pixel_signal && (state == READ);
        rd_in_map = in_range(rd_row_s, rd_col_s);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (layer3_calculation_done) state_next = DONE;
            DONE:    state_next = READ;
            READ:    if (layer4_release) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Stage p0 -> p1: write capture and bookkeeping
    always_ff @(posedge clk) begin
        if (wr_ok) mem[index_of(output_row, output_col)] <= output_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_count      <= '0;
            write_error      <= 1'b0;
            pixel_store_done <= 1'b0;
        end else begin
            pixel_store_done <= (state == DONE);
            if (state == READ && layer4_release) begin
                store_count <= '0;
            end else if (wr_ok && store_count != {ADDR_W{1'b1}}) begin
                store_count <= store_count + ADDR_W'(1);
            end
            if (save_enable && !wr_ok) write_error <= 1'b1;
        end
    end

    // Stage p0 -> p1: read port, out-of-map addresses return zero padding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= rd_req;
            if (rd_req) read_data <= rd_in_map ? mem[index_of(read_row_addr, read_col_addr)] : '0;
        end
    end

endmodule

// File: tb/tb_layer3_pool_store.sv
// Directed bench for layer3_pool_store: fill, handoff pulse, reads with padding,
// dropped writes, same-cycle write/done, and mid-FILL reset.
module tb_layer3_pool_store;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              save_enable;
    logic [ADDR_W-1:0] output_row;
    logic [ADDR_W-1:0] output_col;
    logic [DATA_W-1:0] output_data;
    logic              layer3_calculation_done;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic              layer4_release;
    logic              pixel_store_done;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic [ADDR_W-1:0] store_count;
    logic              write_error;

    int vectors = 0;
    int miscompares = 0;

    layer3_pool_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_H(13), .OUT_W(13)) dut (
        .clk(clk), .rst(rst),
        .save_enable(save_enable), .output_row(output_row), .output_col(output_col),
        .output_data(output_data), .layer3_calculation_done(layer3_calculation_done),
        .read_pixel_signal(read_pixel_signal), .read_row_addr(read_row_addr),
        .read_col_addr(read_col_addr), .layer4_release(layer4_release),
        .pixel_store_done(pixel_store_done), .read_data(read_data),
        .read_valid(read_valid), .store_count(store_count), .write_error(write_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] r, input logic [7:0] c);
        return {8{r, c}};
    endfunction

    task automatic rd(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
        read_pixel_signal = 1'b1;
        read_row_addr = r;
        read_col_addr = c;
        tick();
        read_pixel_signal = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        save_enable = 1'b0;
        output_row = '0;
        output_col = '0;
        output_data = '0;
        layer3_calculation_done = 1'b0;
        read_pixel_signal = 1'b0;
        read_row_addr = '0;
        read_col_addr = '0;
        layer4_release = 1'b0;

        // reset held low for three cycles
        repeat (3) tick();
        chk("rst_done", pixel_store_done, '0);
        chk("rst_data", read_data, '0);
        chk("rst_valid", read_valid, '0);
        chk("rst_count", store_count, '0);
        chk("rst_err", write_error, '0);
        rst = 1'b1;
        tick();

        // raster fill of the whole map
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < 13; c++) begin
                save_enable = 1'b1;
                output_row = ADDR_W'(r);
                output_col = ADDR_W'(c);
                output_data = pat(8'(r), 8'(c));
                tick();
            end
        end
        save_enable = 1'b0;
        chk("fill_count", store_count, 128'd169);
        chk("fill_err", write_error, '0);

        layer3_calculation_done = 1'b1;
        tick();
        layer3_calculation_done = 1'b0;
        chk("done_c1", pixel_store_done, '0);
        tick();
        chk("done_c2", pixel_store_done, 128'd1);
        tick();
        chk("done_c3", pixel_store_done, '0);

        // back-to-back reads
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd5;
        read_col_addr = 16'd7;
        tick();
        chk("rd57_valid", read_valid, 128'd1);
        chk("rd57_data", read_data, {8{16'h0507}});
        read_row_addr = 16'd12;
        read_col_addr = 16'd12;
        tick();
        read_pixel_signal = 1'b0;
        chk("rdCC_valid", read_valid, 128'd1);
        chk("rdCC_data", read_data, {8{16'h0C0C}});

        // padding reads
        rd(16'hFFFF, 16'd0);
        chk("padneg_valid", read_valid, 128'd1);
        chk("padneg_data", read_data, '0);
        rd(16'd3, 16'd4);
        chk("rd34_data", read_data, {8{16'h0304}});
        rd(16'd0, 16'd13);
        chk("padcol_valid", read_valid, 128'd1);
        chk("padcol_data", read_data, '0);
        rd(16'd3, 16'd4);
        tick();
        chk("idle_valid", read_valid, '0);
        chk("idle_hold", read_data, {8{16'h0304}});

        // write in READ is dropped and flagged
        save_enable = 1'b1;
        output_row = 16'd0;
        output_col = 16'd0;
        output_data = {8{16'hDEAD}};
        tick();
        save_enable = 1'b0;
        chk("rdwr_err", write_error, 128'd1);
        chk("rdwr_count", store_count, 128'd169);
        rd(16'd0, 16'd1);
        chk("rd01_data", read_data, {8{16'h0001}});
        rd(16'd0, 16'd0);
        chk("rd00_unchanged", read_data, '0);

        // release back to FILL
        layer4_release = 1'b1;
        tick();
        layer4_release = 1'b0;
        chk("rel_count", store_count, '0);
        rd(16'd5, 16'd7);
        chk("fill_rd_valid", read_valid, '0);

        // out-of-range write in FILL is dropped
        save_enable = 1'b1;
        output_row = 16'd13;
        output_col = 16'd0;
        output_data = {8{16'hBEEF}};
        tick();
        chk("oor_count", store_count, '0);
        chk("oor_err", write_error, 128'd1);

        // write together with calc_done is kept
        output_row = 16'd0;
        output_col = 16'd0;
        output_data = {8{16'h1234}};
        layer3_calculation_done = 1'b1;
        tick();
        save_enable = 1'b0;
        layer3_calculation_done = 1'b0;
        chk("same_count", store_count, 128'd1);
        tick();
        chk("same_done", pixel_store_done, 128'd1);
        rd(16'd0, 16'd0);
        chk("same_rd00", read_data, {8{16'h1234}});
        rd(16'd13, 16'd0);
        chk("padrow_data", read_data, '0);
        rd(16'd5, 16'd7);
        chk("keep57", read_data, {8{16'h0507}});

        // mid-FILL reset
        layer4_release = 1'b1;
        tick();
        layer4_release = 1'b0;
        save_enable = 1'b1;
        output_row = 16'd2;
        output_col = 16'd2;
        tick();
        save_enable = 1'b0;
        chk("pre_rst_count", store_count, 128'd1);
        rst = 1'b0;
        #2;
        chk("mid_rst_count", store_count, '0);
        chk("mid_rst_done", pixel_store_done, '0);
        chk("mid_rst_err", write_error, '0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_valid", read_valid, '0);
        chk("post_rst_count", store_count, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
